// File: rtl/adler32_pkg.sv
// Shared constants and FSM encoding for the multi-byte Adler-32 engine.
package adler32_pkg;

  // Largest prime below 2^16; both running sums are reduced modulo this.
  localparam logic [15:0] ADLER_MOD = 16'd65521;

  // Width of the packed {s2,s1} checksum.
  localparam int CSUM_W = 32;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ACTV_ENC = 2'd1;
  localparam logic [1:0] ST_PROC_ENC = 2'd2;
  localparam logic [1:0] ST_LAST_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ACTV = ST_ACTV_ENC,
    ST_PROC = ST_PROC_ENC,
    ST_LAST = ST_LAST_ENC
  } state_e;

endpackage

// File: rtl/adler32_step.sv
// Combinational k-byte Adler-32 fold: advances {s2,s1} by up to BPC bytes.
// Lane 0 sits in the MSB byte of lanes_i and is the first byte in stream
// order; lanes at index >= k_i contribute nothing.
module adler32_step
  import adler32_pkg::*;
#(
  parameter int BPC = 2,
  parameter int KW  = $clog2(BPC + 1)
) (
  input  logic [15:0]      s1_i,
  input  logic [15:0]      s2_i,
  input  logic [8*BPC-1:0] lanes_i,
  input  logic [KW-1:0]    k_i,
  output logic [15:0]      s1_o,
  output logic [15:0]      s2_o
);

  // Wide enough for s2 + k*s1 + sum((k-i)*b_i) before reduction.
  localparam int S2W = 16 + $clog2(2 * BPC + 2);

  logic [S2W-1:0] byte_term [BPC];
  logic [S2W-1:0] wt_term   [BPC];
  logic [S2W-1:0] sum_b;
  logic [S2W-1:0] sum_w;
  logic [S2W-1:0] s1_raw;
  logic [S2W-1:0] s2_raw;
  logic [BPC+1:0] s2_ge;
  logic [S2W-1:0] s2_cand   [BPC+2];

  // Per-lane masked byte and its positional weight (k - i).
  for (genvar gi = 0; gi < BPC; gi++) begin : g_lane
    logic [7:0] lane_b;
    logic       lane_en;
    assign lane_b        = lanes_i[8*(BPC-gi)-1 -: 8];
    assign lane_en       = (KW'(gi) < k_i);
    assign byte_term[gi] = lane_en ? S2W'(lane_b) : '0;
    assign wt_term[gi]   = lane_en ? S2W'(lane_b) * (S2W'(k_i) - S2W'(gi)) : '0;
  end

  // Adder trees over the active lanes.
  always_comb begin
    sum_b = '0;
    sum_w = '0;
    for (int i = 0; i < BPC; i++) begin
      sum_b = sum_b + byte_term[i];
      sum_w = sum_w + wt_term[i];
    end
  end

  assign s1_raw = S2W'(s1_i) + sum_b;
  assign s2_raw = S2W'(s2_i) + S2W'(k_i) * S2W'(s1_i) + sum_w;

  // s1 grows by at most BPC*255 per fold, so a single subtract suffices.
  always_comb begin
    s1_o = 16'(s1_raw);
    if (s1_raw >= S2W'(ADLER_MOD)) begin
      s1_o = 16'(s1_raw - S2W'(ADLER_MOD));
    end
  end

  // Comparator chain: one candidate remainder per multiple of the modulus.
  for (genvar gi = 0; gi < BPC + 2; gi++) begin : g_mul
    localparam int MUL_I = gi * int'(ADLER_MOD);
    assign s2_ge[gi]   = (s2_raw >= S2W'(MUL_I));
    assign s2_cand[gi] = s2_raw - S2W'(MUL_I);
  end

  // Pick the remainder for the largest multiple that does not exceed s2_raw.
  always_comb begin
    s2_o = 16'(s2_raw);
    for (int m = 0; m < BPC + 2; m++) begin
      if (s2_ge[m]) begin
        s2_o = 16'(s2_cand[m]);
      end
    end
  end

endmodule

// File: rtl/adler32_mb.sv
// Multi-byte Adler-32 engine: accepts DATA_BYTES-wide words over valid/ready
// and folds BYTES_PER_CYC bytes per clock, MSB byte first.
module adler32_mb
  import adler32_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int BYTES_PER_CYC = 2,
  parameter int CNT_WD        = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic [CSUM_W-1:0]       seed_i,
  input  logic                    in_vld_i,
  output logic                    in_rdy_o,
  input  logic [8*DATA_BYTES-1:0] in_dat_i,
  input  logic [CNT_WD-1:0]       in_nbyte_i,
  input  logic                    in_lst_i,
  output logic                    val_o,
  output logic                    done_o,
  output logic [CSUM_W-1:0]       dat_o
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int LW  = 8 * BYTES_PER_CYC;
  localparam int KW  = $clog2(BYTES_PER_CYC + 1);
  localparam int BSH = $clog2(BYTES_PER_CYC);

  state_e            state_q, state_d;
  logic [15:0]       s1_q, s1_d;
  logic [15:0]       s2_q, s2_d;
  logic [CSUM_W-1:0] dat_q, dat_d;
  logic              val_q, val_d;
  logic              done_q, done_d;
  logic [DW-1:0]     word_q, word_d;
  logic [CNT_WD-1:0] rem_q, rem_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              lst_q, lst_d;
  logic              empty_q, empty_d;

  logic [CNT_WD-1:0] in_beats;
  logic [KW-1:0]     step_k;
  logic [DW-1:0]     word_shift;
  logic [15:0]       s1_fold;
  logic [15:0]       s2_fold;

  // Sub-beats needed for the incoming word: ceil(nbyte / BYTES_PER_CYC).
  assign in_beats = CNT_WD'(({1'b0, in_nbyte_i} + (CNT_WD+1)'(BYTES_PER_CYC - 1)) >> BSH);

  // Lanes this fold: a full group, or whatever is left of a partial word.
  assign step_k = (rem_q >= CNT_WD'(BYTES_PER_CYC)) ? KW'(BYTES_PER_CYC) : KW'(rem_q);

  // Advance the word buffer so the next unfolded byte sits at the MSB.
  if (LW < DW) begin : g_shift
    assign word_shift = {word_q[DW-LW-1:0], {LW{1'b0}}};
  end else begin : g_noshift
    assign word_shift = '0;
  end

  adler32_step #(
    .BPC (BYTES_PER_CYC)
  ) u_step (
    .s1_i    (s1_q),
    .s2_i    (s2_q),
    .lanes_i (word_q[DW-1 -: LW]),
    .k_i     (step_k),
    .s1_o    (s1_fold),
    .s2_o    (s2_fold)
  );

  // Next-state and datapath control; start_i overrides everything else.
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dat_d   = dat_q;
    val_d   = 1'b0;
    done_d  = 1'b0;
    word_d  = word_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    lst_d   = lst_q;
    empty_d = empty_q;

    if (start_i) begin
      state_d = ST_ACTV;
      s1_d    = seed_i[15:0];
      s2_d    = seed_i[31:16];
      dat_d   = seed_i;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACTV: begin
          if (in_vld_i) begin
            word_d  = in_dat_i;
            rem_d   = in_nbyte_i;
            cnt_d   = in_beats;
            lst_d   = in_lst_i;
            empty_d = (in_beats == '0);
            state_d = (in_beats == '0) ? ST_LAST : ST_PROC;
          end
        end
        ST_PROC: begin
          s1_d   = s1_fold;
          s2_d   = s2_fold;
          word_d = word_shift;
          rem_d  = rem_q - CNT_WD'(step_k);
          cnt_d  = cnt_q - CNT_WD'(1);
          if (cnt_q == CNT_WD'(1)) begin
            dat_d   = {s2_fold, s1_fold};
            val_d   = 1'b1;
            done_d  = lst_q;
            state_d = lst_q ? ST_LAST : ST_ACTV;
          end
        end
        ST_LAST: begin
          // An empty last word never folded, so its pulse comes from here.
          state_d = ST_IDLE;
          val_d   = empty_q;
          done_d  = empty_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      dat_q   <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      lst_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      done_q  <= done_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      lst_q   <= lst_d;
      empty_q <= empty_d;
    end
  end

  assign in_rdy_o = (state_q == ST_ACTV);
  assign val_o    = val_q;
  assign done_o   = done_q;
  assign dat_o    = dat_q;

endmodule
